// File: rtl/uart_parser_pkg.sv
// Shared definitions for the ASCII-hex line parser: character constants,
// parser state encoding and the hex-digit decoder.
package uart_parser_pkg;

  localparam logic [7:0] CHAR_0    = 8'h30;
  localparam logic [7:0] CHAR_9    = 8'h39;
  localparam logic [7:0] CHAR_A    = 8'h41;
  localparam logic [7:0] CHAR_F    = 8'h46;
  localparam logic [7:0] CHAR_a    = 8'h61;
  localparam logic [7:0] CHAR_f    = 8'h66;
  localparam logic [7:0] CHAR_sp   = 8'h20;
  localparam logic [7:0] CHAR_ht   = 8'h09;
  localparam logic [7:0] CHAR_cr   = 8'h0D;
  localparam logic [7:0] CHAR_lf   = 8'h0A;
  localparam logic [7:0] CHAR_cl   = 8'h3A;
  localparam logic [7:0] CHAR_hash = 8'h23;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    DIGIT   = 3'd1,
    LASTB   = 3'd2,
    INVALID = 3'd3,
    COMMENT = 3'd4
  } state_t;

  // Returns {is_hex, nibble}; nibble is 0 when the character is not hex.
  function automatic logic [4:0] ascii2hex(input logic [7:0] c);
    logic [7:0] t;
    t = 8'h00;
    if (c >= CHAR_0 && c <= CHAR_9) begin
      t = c - CHAR_0;
      return {1'b1, t[3:0]};
    end else if (c >= CHAR_A && c <= CHAR_F) begin
      t = c - 8'd55;
      return {1'b1, t[3:0]};
    end else if (c >= CHAR_a && c <= CHAR_f) begin
      t = c - 8'd87;
      return {1'b1, t[3:0]};
    end
    return 5'b0_0000;
  endfunction

endpackage

// File: rtl/uart_parser_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible whenever empty is low.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_parser_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so outputs read 0 after reset.
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_hex_parser_p.sv
// ASCII-hex line parser: packs hex digits into NIBBLES-digit words behind a
// show-ahead FIFO. Define UART_PARSER_COMMENT_EN to treat '#' as a comment start.
module uart_rx_hex_parser_p
  import uart_parser_pkg::*;
#(
  parameter  int NIBBLES    = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int DW         = 4 * NIBBLES,
  localparam int BW         = $clog2(DW + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx_byte_en,
  input  logic [7:0]    uart_rx_byte,
  input  logic          m_tready,
  output logic          m_tvalid,
  output logic [DW-1:0] m_tdata,
  output logic [BW-1:0] m_tbits,
  output logic          m_tlast,
  output logic          overflow,
  output logic [15:0]   err_cnt
);
  localparam int NW = $clog2(NIBBLES + 1);
  localparam int FW = DW + BW + 1;

  state_t        state_reg, state_next;
  logic [DW-1:0] acc_reg, acc_next;
  logic [NW-1:0] ncnt_reg, ncnt_next;

  logic [4:0]    hx;
  logic [3:0]    nib;
  logic          is_hex, is_space, is_eol, is_colon, is_hash;
  logic          push_req, push_last, pop, full, empty, drop;
  logic [BW-1:0] push_bits;
  logic [FW-1:0] fifo_din, fifo_dout;

  assign hx       = ascii2hex(uart_rx_byte);
  assign is_hex   = hx[4];
  assign nib      = hx[3:0];
  assign is_space = (uart_rx_byte == CHAR_sp) || (uart_rx_byte == CHAR_ht);
  assign is_eol   = (uart_rx_byte == CHAR_cr) || (uart_rx_byte == CHAR_lf);
  assign is_colon = (uart_rx_byte == CHAR_cl);
  assign is_hash  = (uart_rx_byte == CHAR_hash);

  assign m_tvalid = !empty;
  assign pop      = m_tvalid && m_tready;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    ncnt_next  = ncnt_reg;
    push_req   = 1'b0;
    push_last  = 1'b0;
    push_bits  = BW'(DW);
    if (uart_rx_byte_en) begin
      case (state_reg)
        INIT: begin
          if (is_hex) begin
            acc_next   = DW'(nib);
            ncnt_next  = NW'(1);
            state_next = DIGIT;
          end else if (is_space || is_eol) begin
            state_next = INIT;
`ifdef UART_PARSER_COMMENT_EN
          end else if (is_hash) begin
            state_next = COMMENT;
`endif
          end else begin
            state_next = INVALID;
          end
        end
        DIGIT: begin
          if (is_hex) begin
            if (ncnt_reg == NW'(NIBBLES)) begin
              push_req  = 1'b1;
              acc_next  = DW'(nib);
              ncnt_next = NW'(1);
            end else begin
              acc_next  = DW'({acc_reg, nib});
              ncnt_next = ncnt_reg + 1'b1;
            end
          end else if (is_space) begin
            state_next = DIGIT;
          end else if (is_colon) begin
            state_next = LASTB;
          end else if (is_eol) begin
            push_req   = 1'b1;
            push_last  = 1'b1;
            state_next = INIT;
`ifdef UART_PARSER_COMMENT_EN
          end else if (is_hash) begin
            push_req   = 1'b1;
            push_last  = 1'b1;
            state_next = COMMENT;
`endif
          end else begin
            push_req   = 1'b1;
            push_last  = 1'b1;
            state_next = INVALID;
          end
        end
        LASTB: begin
          // A zero-width word is meaningless, so ':0' is reported as 1 bit.
          if (is_hex) begin
            push_req  = 1'b1;
            push_last = 1'b1;
            if (nib == 4'd0)        push_bits = BW'(1);
            else if (int'(nib) < DW) push_bits = BW'(nib);
            else                     push_bits = BW'(DW);
            state_next = INVALID;
          end else if (is_eol) begin
            push_req   = 1'b1;
            push_last  = 1'b1;
            state_next = INIT;
          end else if (is_space) begin
            state_next = LASTB;
          end else begin
            push_req   = 1'b1;
            push_last  = 1'b1;
            state_next = INVALID;
          end
        end
        default: begin
          // INVALID and COMMENT both wait for end of line.
          if (is_eol) state_next = INIT;
        end
      endcase
    end
    // A dropped word poisons the rest of the line.
    drop = push_req && full && !pop;
    if (drop) state_next = INVALID;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= INIT;
      acc_reg   <= '0;
      ncnt_reg  <= '0;
      overflow  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      ncnt_reg  <= ncnt_next;
      overflow  <= drop;
      if (state_next == INVALID && state_reg != INVALID && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign fifo_din = {push_last, push_bits, acc_reg};

  uart_parser_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign m_tdata = fifo_dout[DW-1:0];
  assign m_tbits = fifo_dout[DW+BW-1:DW];
  assign m_tlast = fifo_dout[FW-1];

endmodule

// File: doc/uart_rx_hex_parser_p.md
Name: uart_rx_hex_parser_p

Overview:
Parametrised ASCII-hex line parser. Sits between the UART byte receiver and command/frame consumers.
Converts hex characters into words of NIBBLES nibbles each. Marks the end of each line with a last flag and carries a valid-bit count for the final word.
Outputs through an internal FIFO with a valid/ready handshake (backpressure). Reports overflow and counts malformed lines.

Parameters:
NIBBLES, 2, hex digits per output word; DW = 4*NIBBLES, legal range 1..8
FIFO_DEPTH, 4, output FIFO entries, power of 2, >= 2
BW, $clog2(DW+1), width of m_tbits (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
uart_rx_byte_en  in  1  one-cycle strobe; uart_rx_byte is valid this cycle
uart_rx_byte  in  8  received ASCII character
m_tready  in  1  consumer ready
m_tvalid  out  1  FIFO head valid
m_tdata  out  DW  parsed word, right-justified
m_tbits  out  BW  valid bits in the word (DW unless set by a ':' suffix)
m_tlast  out  1  last word of the line
overflow  out  1  one-cycle pulse when a push is dropped because the FIFO is full
err_cnt  out  16  count of lines that entered INVALID; saturates at 16'hFFFF

Behaviour:
- Reset: async on rst high. All outputs 0, FIFO empty, state INIT, nibble count 0, accumulator 0.
- Character classes:
  - hex: 0-9, A-F, a-f
  - space: 0x20, 0x09
  - eol: 0x0D, 0x0A
  - colon: 0x3A
  - everything else is "other"
- Characters are processed only on cycles where uart_rx_byte_en is high.
- Accumulator (acc, DW bits): a hex digit shifts in at the LSB: acc <= {acc[DW-5:0], nib}. Digit count ncnt runs 0..NIBBLES.
- States:
  - INIT:
    - hex: acc = nib, ncnt = 1, go to DIGIT.
    - space/eol: stay in INIT.
    - colon/other: go to INVALID.
  - DIGIT:
    - hex with ncnt < NIBBLES: shift it in, ncnt+1.
    - hex with ncnt == NIBBLES: push {acc, DW, last=0}, then acc = nib, ncnt = 1.
    - space: ignored, stay in DIGIT.
    - colon: go to LASTB.
    - eol: push {acc, DW, last=1}, go to INIT.
    - other: push {acc, DW, last=1}, go to INVALID.
  - LASTB:
    - hex d: push with last=1 and m_tbits as follows:
      - d = 0 gives 1
      - 1 <= d < DW gives d
      - otherwise DW
      Then go to INVALID; the rest of the line is ignored.
    - eol: push {acc, DW, 1}, go to INIT.
    - other: push {acc, DW, 1}, go to INVALID.
  - INVALID: eol returns to INIT; everything else is ignored.
- A partial word is right-justified with zero upper bits (one-digit word "A" gives 0x0A for DW=8).
- err_cnt increments on every transition into INVALID from any other state. This includes overflow (see FIFO). It saturates at 16'hFFFF.
- FIFO:
  - Push is decided combinationally from the current byte and written on the same clk edge. m_tvalid is high in the cycle after the byte strobe (latency 1).
  - Head is show-ahead: m_tdata/m_tbits/m_tlast are stable while m_tvalid && !m_tready.
  - Pop occurs on m_tvalid && m_tready.
  - Push and pop in the same cycle when full: the push is accepted.
  - Push when full with no pop: entry dropped, overflow pulses for 1 cycle, state forced to INVALID (rest of line dropped, err_cnt+1).
- Reset mid-line or with the FIFO non-empty discards all contents. No partial word survives reset.

Optional Feature:
UART_PARSER_COMMENT_EN.
- Defined: '#' (0x23) in INIT goes to state COMMENT, which ignores all characters until eol and then returns to INIT. '#' in DIGIT first pushes {acc, DW, last=1}, then enters COMMENT. Entering COMMENT does not count as an error.
- Undefined: '#' is "other" and follows the INVALID rules.

Decomposition:
- Package uart_parser_pkg holds:
  - ASCII constants (CHAR_0, CHAR_9, CHAR_A, CHAR_F, CHAR_a, CHAR_f, CHAR_sp, CHAR_ht, CHAR_cr, CHAR_lf, CHAR_cl, CHAR_hash)
  - state encoding (INIT, DIGIT, LASTB, INVALID, COMMENT)
  - ascii2hex function returning {is_hex, nib}
- One sub-module: uart_parser_fifo, a synchronous show-ahead FIFO with width DW+BW+1, depth FIFO_DEPTH, and full/empty/push/pop ports.

Test Plan:
1. NIBBLES=2, m_tready=1, send "12 34\n" -> 0x12 (last=0, bits=8), then 0x34 (last=1, bits=8); err_cnt=0.
2. Send "ABC\r" -> 0xAB (last=0), then 0x0C (last=1, bits=8).
3. Send "5A:3\n" -> 0x5A (last=1, bits=3). Then "7:0\n" -> 0x07 (last=1, bits=1). Then "7:F\n" -> bits=8.
4. Send "1G2\n" then "FF\n" -> 0x01 (last=1), err_cnt=1, '2' ignored, then 0xFF (last=1).
5. FIFO_DEPTH=4, m_tready=0, send "0102030405\n" -> four entries 01..04 held, overflow pulses once on the 5th word, err_cnt=1. Raise m_tready -> 01, 02, 03, 04 drain in order, all with last=0.
6. NIBBLES=4, send "DEADBEEF\n" -> 0xDEAD (last=0), then 0xBEEF (last=1, bits=16). Assert rst mid-way through "12" -> no output, m_tvalid=0.
